// File: rtl/arbitro_cdb_pkg.sv
// Shared definitions for the common data bus arbiter: widths, reserved tags
// and the per-requester buffer states.
package arbitro_cdb_pkg;

    localparam int LARG  = 16;
    localparam int TAG_W = 3;

    localparam logic [TAG_W-1:0] TAG_NENHUM = 3'd0;
    localparam logic [TAG_W-1:0] TAG_ADDSUB = 3'd1;
    localparam logic [TAG_W-1:0] TAG_MULDIV = 3'd2;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_buf_t;

endpackage

// File: rtl/arbitro_cdb_if.sv
// Request/accept and broadcast signals of the CDB arbiter, bundled so that
// functional units (master) and the arbiter (slave) share one port.
interface arbitro_cdb_if
    import arbitro_cdb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LARG = arbitro_cdb_pkg::LARG
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*LARG-1:0]  dadoIn;
    logic [NREQ*TAG_W-1:0] tagIn;
    logic                  limpa;
    logic [NREQ-1:0]       ack;
    logic                  writeCDB;
    logic [LARG-1:0]       dadoCDB;
    logic [TAG_W-1:0]      RS_Name;
    logic                  erroTag;

    modport master (
        output req, dadoIn, tagIn, limpa,
        input  ack, writeCDB, dadoCDB, RS_Name, erroTag
    );

    modport slave (
        input  req, dadoIn, tagIn, limpa,
        output ack, writeCDB, dadoCDB, RS_Name, erroTag
    );

endinterface

// File: rtl/arbitro_cdb_rr_seletor.sv
// Round-robin pick of one full buffer, searching from the slot after the
// last winner so every full buffer is served within NREQ cycles.
module rr_seletor #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_cheio,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_valid
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % NREQ);
            if (!o_valid && i_cheio[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_cdb.sv
// Common data bus arbiter: one single-entry buffer per requester, round-robin
// broadcast of one buffered result per cycle, tag-0 results rejected.
module arbitro_cdb
    import arbitro_cdb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LARG = arbitro_cdb_pkg::LARG
) (
    input  logic          clock,
    input  logic          reset,
    arbitro_cdb_if.slave  bus
);

    localparam int PW = $clog2(NREQ);

    estado_buf_t      r_estado     [NREQ];
    estado_buf_t      w_proxEstado [NREQ];
    logic [LARG-1:0]  r_dado       [NREQ];
    logic [TAG_W-1:0] r_tag        [NREQ];
    logic [PW-1:0]    r_ptr;

    logic             r_writeCDB;
    logic [LARG-1:0]  r_dadoCDB;
    logic [TAG_W-1:0] r_rsName;
    logic             r_erroTag;

    logic [NREQ-1:0]  w_cheio;
    logic [NREQ-1:0]  w_tagZero;
    logic [NREQ-1:0]  w_grantBruto;
    logic [NREQ-1:0]  w_grant;
    logic             w_valid;
    logic             w_grantValid;
    logic [NREQ-1:0]  w_ack;
    logic [NREQ-1:0]  w_load;
    logic [PW-1:0]    w_ptrGrant;
    logic [LARG-1:0]  w_dadoGrant;
    logic [TAG_W-1:0] w_tagGrant;

    always_comb begin
        w_cheio   = '0;
        w_tagZero = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cheio[i]   = (r_estado[i] == CHEIO);
            w_tagZero[i] = (bus.tagIn[i*TAG_W +: TAG_W] == TAG_NENHUM);
        end
    end

    rr_seletor #(.NREQ(NREQ)) u_seletor (
        .i_cheio (w_cheio),
        .i_ptr   (r_ptr),
        .o_grant (w_grantBruto),
        .o_valid (w_valid)
    );

    // A flush suppresses the broadcast, so it also suppresses the grant.
    assign w_grantValid = w_valid & ~bus.limpa;
    assign w_grant      = bus.limpa ? '0 : w_grantBruto;

    // A full buffer can accept only when it is being emptied by this grant.
    always_comb begin
        w_ack  = '0;
        w_load = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ack[i]  = bus.req[i] & ~bus.limpa & ~reset & (~w_cheio[i] | w_grant[i]);
            w_load[i] = w_ack[i] & ~w_tagZero[i];
        end
    end

    assign bus.ack = w_ack;

    always_comb begin
        w_ptrGrant  = '0;
        w_dadoGrant = '0;
        w_tagGrant  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_ptrGrant  = PW'(i);
                w_dadoGrant = r_dado[i];
                w_tagGrant  = r_tag[i];
            end
        end
    end

    // Reload wins over the grant so a buffer sent and refilled stays full.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_proxEstado[i] = r_estado[i];
            if (bus.limpa)
                w_proxEstado[i] = VAZIO;
            else if (w_load[i])
                w_proxEstado[i] = CHEIO;
            else if (w_ack[i] || w_grant[i])
                w_proxEstado[i] = VAZIO;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_estado[i] <= VAZIO;
                r_dado[i]   <= '0;
                r_tag[i]    <= '0;
            end
            r_ptr      <= PW'(NREQ - 1);
            r_writeCDB <= 1'b0;
            r_dadoCDB  <= '0;
            r_rsName   <= '0;
            r_erroTag  <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_estado[i] <= w_proxEstado[i];
                if (w_load[i]) begin
                    r_dado[i] <= bus.dadoIn[i*LARG +: LARG];
                    r_tag[i]  <= bus.tagIn[i*TAG_W +: TAG_W];
                end
            end
            if (w_grantValid) begin
                r_ptr      <= w_ptrGrant;
                r_writeCDB <= 1'b1;
                r_dadoCDB  <= w_dadoGrant;
                r_rsName   <= w_tagGrant;
            end else begin
                r_writeCDB <= 1'b0;
            end
            r_erroTag <= |(w_ack & w_tagZero);
        end
    end

    assign bus.writeCDB = r_writeCDB;
    assign bus.dadoCDB  = r_dadoCDB;
    assign bus.RS_Name  = r_rsName;
    assign bus.erroTag  = r_erroTag;

endmodule

// File: tb/tb_arbitro_cdb.sv
// Directed bench for arbitro_cdb: a buffer-level model checked every falling
// edge, plus literal expectations for the documented scenarios.
module tb_arbitro_cdb;
    import arbitro_cdb_pkg::*;

    localparam int NREQ = 4;
    localparam int LW   = 16;

    logic clock = 1'b0;
    logic reset;

    int nVec = 0;
    int nErr = 0;

    always #5 clock = ~clock;

    arbitro_cdb_if #(.NREQ(NREQ), .LARG(LW)) bus ();

    arbitro_cdb #(.NREQ(NREQ), .LARG(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Model state: what each requester's slot holds and what the bus shows.
    bit          mFull [NREQ];
    logic [15:0] mDado [NREQ];
    logic [2:0]  mTag  [NREQ];
    int          mPtr;
    logic        expWrite;
    logic [15:0] expDado;
    logic [2:0]  expRS;
    logic        expErro;

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        nVec++;
        if (atual !== esperado) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic int modelGrant();
        if (bus.limpa) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (mPtr + k) % NREQ;
            if (mFull[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] modelAck(input int g);
        logic [NREQ-1:0] a;
        a = '0;
        for (int i = 0; i < NREQ; i++)
            a[i] = bus.req[i] && !bus.limpa && (!mFull[i] || i == g);
        return a;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREQ; i++) begin
            mFull[i] = 1'b0;
            mDado[i] = '0;
            mTag[i]  = '0;
        end
        mPtr     = NREQ - 1;
        expWrite = 1'b0;
        expDado  = '0;
        expRS    = '0;
        expErro  = 1'b0;
    endtask

    // Advance the model over the coming rising edge using the inputs now held.
    task automatic modelStep();
        int g;
        logic [NREQ-1:0] a;
        logic [2:0] t;
        g = modelGrant();
        a = modelAck(g);
        if (bus.limpa) begin
            for (int i = 0; i < NREQ; i++) mFull[i] = 1'b0;
            expWrite = 1'b0;
            expErro  = 1'b0;
        end else begin
            if (g >= 0) begin
                expWrite = 1'b1;
                expDado  = mDado[g];
                expRS    = mTag[g];
                mPtr     = g;
                mFull[g] = 1'b0;
            end else begin
                expWrite = 1'b0;
            end
            expErro = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (a[i]) begin
                    t = bus.tagIn[i*3 +: 3];
                    if (t != TAG_NENHUM) begin
                        mFull[i] = 1'b1;
                        mDado[i] = bus.dadoIn[i*16 +: 16];
                        mTag[i]  = t;
                    end else begin
                        expErro = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) modelReset();
        checkOutput("model writeCDB", 32'(bus.writeCDB), 32'(expWrite));
        checkOutput("model dadoCDB",  32'(bus.dadoCDB),  32'(expDado));
        checkOutput("model RS_Name",  32'(bus.RS_Name),  32'(expRS));
        checkOutput("model erroTag",  32'(bus.erroTag),  32'(expErro));
        checkOutput("model ack",      32'(bus.ack),      reset ? 32'd0 : 32'(modelAck(modelGrant())));
        if (!reset) modelStep();
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [11:0] tags, input logic [63:0] dados, input logic l);
        bus.req    = r;
        bus.tagIn  = tags;
        bus.dadoIn = dados;
        bus.limpa  = l;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [3:0]  r;
        logic [11:0] tags;
        logic        l;
    } linha_t;

    linha_t tabela [8];

    initial begin
        reset = 1'b1;
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        #2;
        checkOutput("reset writeCDB", 32'(bus.writeCDB), 32'd0);
        checkOutput("reset dadoCDB",  32'(bus.dadoCDB),  32'd0);
        checkOutput("reset RS_Name",  32'(bus.RS_Name),  32'd0);
        checkOutput("reset erroTag",  32'(bus.erroTag),  32'd0);
        applyStimulus(4'hF, {3'd1, 3'd1, 3'd1, 3'd1}, 64'h1111_2222_3333_4444, 1'b0);
        #1;
        checkOutput("ack during reset", 32'(bus.ack), 32'd0);
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        step();

        // Single request on requester 1
        applyStimulus(4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, {16'h0, 16'h0, 16'h00AB, 16'h0}, 1'b0);
        #1 checkOutput("single ack", 32'(bus.ack), 32'h2);
        step();
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        checkOutput("single load edge writeCDB", 32'(bus.writeCDB), 32'd0);
        step();
        checkOutput("single writeCDB", 32'(bus.writeCDB), 32'd1);
        checkOutput("single RS_Name",  32'(bus.RS_Name),  32'd2);
        checkOutput("single dadoCDB",  32'(bus.dadoCDB),  32'h00AB);
        step();
        checkOutput("single end writeCDB", 32'(bus.writeCDB), 32'd0);

        // All four at once after reset: served 0,1,2,3
        doReset();
        applyStimulus(4'hF, {3'd4, 3'd3, 3'd2, 3'd1}, {16'h1003, 16'h1002, 16'h1001, 16'h1000}, 1'b0);
        #1 checkOutput("all four ack", 32'(bus.ack), 32'hF);
        step();
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("all four writeCDB", 32'(bus.writeCDB), 32'd1);
            checkOutput("all four RS_Name",  32'(bus.RS_Name),  32'(k + 1));
            checkOutput("all four dadoCDB",  32'(bus.dadoCDB),  32'h1000 + 32'(k));
        end
        step();
        checkOutput("all four end writeCDB", 32'(bus.writeCDB), 32'd0);

        // Back-to-back on requester 0: grant and reload the same buffer
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0001, {9'd0, 3'd1}, {48'd0, 16'(16'h2000 + k)}, 1'b0);
            #1 checkOutput("b2b ack", 32'(bus.ack), 32'h1);
            if (k >= 2) begin
                checkOutput("b2b writeCDB", 32'(bus.writeCDB), 32'd1);
                checkOutput("b2b dadoCDB",  32'(bus.dadoCDB),  32'h2000 + 32'(k - 2));
            end
            step();
        end
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        checkOutput("b2b tail dadoCDB", 32'(bus.dadoCDB), 32'h2004);
        step();
        checkOutput("b2b last dadoCDB", 32'(bus.dadoCDB), 32'h2005);
        checkOutput("b2b last writeCDB", 32'(bus.writeCDB), 32'd1);
        step();
        checkOutput("b2b end writeCDB", 32'(bus.writeCDB), 32'd0);

        // Tag 0 on requester 3
        applyStimulus(4'b1000, {3'd0, 9'd0}, {16'hDEAD, 48'd0}, 1'b0);
        #1 checkOutput("tag0 ack", 32'(bus.ack), 32'h8);
        step();
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        checkOutput("tag0 erroTag",  32'(bus.erroTag),  32'd1);
        checkOutput("tag0 writeCDB", 32'(bus.writeCDB), 32'd0);
        step();
        checkOutput("tag0 erroTag end", 32'(bus.erroTag),  32'd0);
        checkOutput("tag0 no write",    32'(bus.writeCDB), 32'd0);

        // Flush with buffers 0 and 2 full
        applyStimulus(4'b0101, {3'd0, 3'd2, 3'd0, 3'd1}, {16'h0, 16'h3002, 16'h0, 16'h3000}, 1'b0);
        step();
        applyStimulus(4'hF, {3'd1, 3'd1, 3'd1, 3'd1}, {4{16'h3333}}, 1'b1);
        #1 checkOutput("limpa ack", 32'(bus.ack), 32'd0);
        step();
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("limpa writeCDB", 32'(bus.writeCDB), 32'd0);
            step();
        end

        // Asynchronous reset in the middle of a broadcast
        applyStimulus(4'b0010, {6'd0, 3'd2, 3'd0}, {16'h0, 16'h0, 16'h00CD, 16'h0}, 1'b0);
        step();
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        step();
        checkOutput("pre-reset writeCDB", 32'(bus.writeCDB), 32'd1);
        checkOutput("pre-reset dadoCDB",  32'(bus.dadoCDB),  32'h00CD);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset writeCDB", 32'(bus.writeCDB), 32'd0);
        checkOutput("async reset dadoCDB",  32'(bus.dadoCDB),  32'd0);
        checkOutput("async reset RS_Name",  32'(bus.RS_Name),  32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        step();
        checkOutput("post-reset writeCDB", 32'(bus.writeCDB), 32'd0);

        // Mixed contention, errors and flush, checked by the model only
        tabela[0] = '{4'hF, {3'd2, 3'd1, 3'd2, 3'd1}, 1'b0};
        tabela[1] = '{4'h5, {3'd2, 3'd2, 3'd2, 3'd2}, 1'b0};
        tabela[2] = '{4'hA, {3'd1, 3'd0, 3'd0, 3'd0}, 1'b0};
        tabela[3] = '{4'h0, 12'h0, 1'b0};
        tabela[4] = '{4'hF, {3'd3, 3'd0, 3'd2, 3'd1}, 1'b1};
        tabela[5] = '{4'h3, {3'd0, 3'd0, 3'd1, 3'd2}, 1'b0};
        tabela[6] = '{4'hC, {3'd4, 3'd5, 3'd0, 3'd0}, 1'b0};
        tabela[7] = '{4'h9, {3'd1, 3'd0, 3'd0, 3'd2}, 1'b0};
        for (int n = 0; n < 8; n++) begin
            applyStimulus(tabela[n].r, tabela[n].tags,
                          {16'(16'h4003 + 16 * n), 16'(16'h4002 + 16 * n),
                           16'(16'h4001 + 16 * n), 16'(16'h4000 + 16 * n)},
                          tabela[n].l);
            step();
        end
        applyStimulus(4'h0, 12'h0, 64'h0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        checkOutput("drained writeCDB", 32'(bus.writeCDB), 32'd0);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/arbitro_cdb.md
ARBITRO_CDB -- requirements
Module: arbitro_cdb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (reservation stations / functional units) sharing the CDB.
REQ-002 Parameter: LARG, 16, data width of one CDB result.
REQ-003 Port: clock  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  NREQ  per-requester result-valid request.
REQ-006 Port: dadoIn  input  NREQ*LARG  per-requester result data; slice i belongs to requester i.
REQ-007 Port: tagIn  input  NREQ*3  per-requester reservation-station tag; 0 means "no station".
REQ-008 Port: limpa  input  1  synchronous flush of all buffered results.
REQ-009 Port: ack  output  NREQ  per-requester accept, combinational.
REQ-010 Port: writeCDB  output  1  registered broadcast strobe to the register bank and stations.
REQ-011 Port: dadoCDB  output  LARG  registered broadcast data.
REQ-012 Port: RS_Name  output  3  registered broadcast tag.
REQ-013 Port: erroTag  output  1  registered one-cycle pulse when a tag-0 request is accepted.

Function
REQ-014 Each requester i SHALL own one internal buffer with two states: VAZIO (empty) and CHEIO (holds data plus tag).
REQ-015 ack[i] SHALL be req[i] & !limpa & (buffer i VAZIO | buffer i granted this cycle).
REQ-016 On a posedge with ack[i]=1 and tagIn slice i non-zero, buffer i SHALL load dadoIn/tagIn slice i and enter or stay in CHEIO.
REQ-017 On a posedge with ack[i]=1 and tag 0, the result SHALL be discarded, buffer i SHALL go to or stay VAZIO, and erroTag SHALL be 1 for the next cycle.
REQ-018 Each cycle at most one CHEIO buffer SHALL be granted, chosen round-robin: search order ptr+1, ptr+2, ... mod NREQ.
REQ-019 On a grant to buffer g: at the posedge, writeCDB<=1, dadoCDB<=buffer g data, RS_Name<=buffer g tag, ptr<=g, and buffer g goes VAZIO unless reloaded per REQ-016.
REQ-020 With no grant, writeCDB SHALL be 0 at the next posedge; dadoCDB and RS_Name SHALL hold their last values.
REQ-021 Latency: request accepted at edge t SHALL broadcast no earlier than edge t+1; result is visible on the CDB during cycle t+1 at the earliest.
REQ-022 Each broadcast SHALL last exactly one cycle; no result SHALL be broadcast twice or dropped unless tag is 0 or limpa intervenes.
REQ-023 Fairness: a CHEIO buffer SHALL be granted within NREQ cycles.
REQ-024 limpa=1 SHALL, at the posedge, force all buffers VAZIO, writeCDB<=0, and block all acks; ptr is unchanged.
REQ-025 Simultaneous grant and reload of the same buffer SHALL broadcast the old entry and keep the new one CHEIO.
REQ-026 Outputs SHALL change only on posedge so the negedge-clocked register bank samples stable values.

Reset
REQ-027 reset=1 SHALL immediately set all buffers VAZIO, ptr=NREQ-1, writeCDB=0, dadoCDB=0, RS_Name=0, erroTag=0.
REQ-028 ack SHALL be 0 while reset=1.
REQ-029 Reset mid-broadcast SHALL drop writeCDB at once; buffered results are lost.

Structure
REQ-030 Shared package SHALL hold LARG, tag width 3, the reserved tag value 0 (TAG_NENHUM), and station tag constants (1 AddSub, 2 MulDiv).
REQ-031 Round-robin selection SHALL be one sub-module, rr_seletor (inputs: CHEIO vector and ptr; outputs: grant one-hot and valid).

Verification
REQ-032 Single request: req[1], tag 2, data 0x00AB at edge 0 -> ack[1]=1, cycle 1: writeCDB=1, RS_Name=2, dadoCDB=0x00AB; cycle 2: writeCDB=0.
REQ-033 All four request in the same cycle after reset, tags 1..4 -> broadcasts in order 0,1,2,3 on four consecutive cycles.
REQ-034 Back-to-back from requester 0, with req[0] held and new data each edge, others idle -> one broadcast per cycle, acks continuous, data order preserved.
REQ-035 Tag 0 request on requester 3 -> ack[3]=1, erroTag=1 for one cycle, no writeCDB.
REQ-036 Buffers 0 and 2 CHEIO, limpa pulsed one cycle -> no broadcast at that edge or after, acks 0 during limpa.
REQ-037 Reset asserted asynchronously while writeCDB=1 -> writeCDB, dadoCDB and RS_Name read 0 before the next clock edge.
